prg_loader: RTL and testbench

Parametrised PRG-image loader sitting between `hps_io`'s ioctl download port and the PET's main RAM DMA port. It strips the 2-byte little-endian load-address header and streams the payload into memory through a ready/valid write port, back-pressuring the HPS with `ioctl_wait`. On completion it optionally patches the BASIC end-of-program pointers so `RUN` works without a `LOAD`. It replaces the ad-hoc `dma_off` capture in the top level.

---
 rtl/prg_loader.sv | 182 ++++++++++++++++++
 tb/tb_prg_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// prg_loader: strips the 2-byte little-endian load-address header from an
// ioctl download and streams the payload into RAM through a ready/valid
// write port. When the download ends cleanly, it can also patch the BASIC
// end-of-program pointers.
module prg_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [7:0]  DL_INDEX  = 8'h41,
    parameter int unsigned PTR_COUNT = 3,
    parameter logic [15:0] PTR_BASE  = 16'h002A
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W:0]   end_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, WRITE, PTR, FIN
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_BASE_A = ADDR_W'(PTR_BASE);
    localparam logic [7:0]        PTR_LAST   = (PTR_COUNT > 0) ? 8'(2 * PTR_COUNT - 1) : 8'd0;
    localparam bit                PTR_EN     = (PTR_COUNT > 0);

    state_t              state, state_n;
    logic [24:0]         byte_cnt, byte_cnt_n;
    logic [7:0]          hdr_lo, hdr_lo_n;
    // One bit wider than the address so "one past the top of memory" is representable
    logic [ADDR_W:0]     wptr, wptr_n;
    logic [ADDR_W-1:0]   load_addr_n, mem_addr_n;
    logic [ADDR_W:0]     end_addr_n;
    logic [7:0]          mem_din_n, ptr_idx, ptr_idx_n;
    logic                mem_we_n, error_n;
    logic                wr_hit, addr_bad;
    logic [15:0]         end16;

    assign wr_hit     = ioctl_wr && (ioctl_index == DL_INDEX);
    assign addr_bad   = (ioctl_addr != byte_cnt);
    assign end16      = 16'(end_addr);
    assign ioctl_wait = (state == WRITE);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            hdr_lo    <= '0;
            wptr      <= '0;
            load_addr <= '0;
            end_addr  <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            error     <= 1'b0;
            ptr_idx   <= '0;
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            hdr_lo    <= hdr_lo_n;
            wptr      <= wptr_n;
            load_addr <= load_addr_n;
            end_addr  <= end_addr_n;
            mem_addr  <= mem_addr_n;
            mem_din   <= mem_din_n;
            mem_we    <= mem_we_n;
            error     <= error_n;
            ptr_idx   <= ptr_idx_n;
        end
    end

    // Next-state and next-register computation
    always_comb begin
        state_n     = state;
        byte_cnt_n  = byte_cnt;
        hdr_lo_n    = hdr_lo;
        wptr_n      = wptr;
        load_addr_n = load_addr;
        end_addr_n  = end_addr;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        mem_we_n    = mem_we;
        error_n     = error;
        ptr_idx_n   = ptr_idx;
        case (state)
            IDLE: begin
                if (ioctl_download && (ioctl_index == DL_INDEX)) begin
                    state_n    = HDR_LO;
                    error_n    = 1'b0;
                    byte_cnt_n = '0;
                end
            end
            HDR_LO: begin
                if (!ioctl_download) begin
                    error_n = 1'b1;
                    state_n = FIN;
                end else if (wr_hit) begin
                    byte_cnt_n = byte_cnt + 25'd1;
                    if (addr_bad) error_n = 1'b1;
                    hdr_lo_n = ioctl_dout;
                    state_n  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (!ioctl_download) begin
                    error_n = 1'b1;
                    state_n = FIN;
                end else if (wr_hit) begin
                    byte_cnt_n = byte_cnt + 25'd1;
                    if (addr_bad) error_n = 1'b1;
                    load_addr_n = ADDR_W'({ioctl_dout, hdr_lo});
                    wptr_n      = {1'b0, ADDR_W'({ioctl_dout, hdr_lo})};
                    end_addr_n  = {1'b0, ADDR_W'({ioctl_dout, hdr_lo})};
                    state_n     = DATA;
                end
            end
            DATA: begin
                if (!ioctl_download) begin
                    // Pointers only describe a real program: need payload and a clean load
                    if (PTR_EN && (end_addr != {1'b0, load_addr}) && !error) begin
                        ptr_idx_n = '0;
                        state_n   = PTR;
                    end else begin
                        state_n = FIN;
                    end
                end else if (wr_hit) begin
                    byte_cnt_n = byte_cnt + 25'd1;
                    if (addr_bad) error_n = 1'b1;
                    if (wptr[ADDR_W]) begin
                        error_n = 1'b1;
                    end else begin
                        mem_addr_n = wptr[ADDR_W-1:0];
                        mem_din_n  = ioctl_dout;
                        mem_we_n   = 1'b1;
                        state_n    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_hit) error_n = 1'b1;
                if (mem_ready) begin
                    mem_we_n   = 1'b0;
                    wptr_n     = wptr + 1'b1;
                    end_addr_n = wptr + 1'b1;
                    state_n    = DATA;
                end
            end
            PTR: begin
                if (!mem_we) begin
                    mem_addr_n = PTR_BASE_A + ADDR_W'(ptr_idx);
                    mem_din_n  = ptr_idx[0] ? end16[15:8] : end16[7:0];
                    mem_we_n   = 1'b1;
                end else if (mem_ready) begin
                    mem_we_n = 1'b0;
                    if (ptr_idx == PTR_LAST) state_n = FIN;
                    else                     ptr_idx_n = ptr_idx + 8'd1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prg_loader.sv
// Testbench for prg_loader: directed table of loads, hand-written corner
// sequences, and randomized loads checked against a file-level model.
module tb_prg_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [15:0] load_addr;
    logic [16:0] end_addr;
    logic        busy, done, error;

    prg_loader #(.ADDR_W(16), .DL_INDEX(8'h41), .PTR_COUNT(3), .PTR_BASE(16'h002A)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ready(mem_ready),
        .load_addr(load_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Memory-side ready generator: 0 always ready, 1 five-cycle stall per write,
    // 2 random, 3 never ready
    int rdy_mode = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: mem_ready = 1'b1;
            1: begin
                if (mem_we) begin
                    if (stall_cnt >= 5) begin mem_ready = 1'b1; stall_cnt = 0; end
                    else begin mem_ready = 1'b0; stall_cnt++; end
                end else begin
                    mem_ready = 1'b0;
                    stall_cnt = 0;
                end
            end
            2: mem_ready = ($urandom_range(0, 3) != 0);
            default: mem_ready = 1'b0;
        endcase
    end

    // Observer: logs accepted writes, counts done pulses, watches hold stability
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    int          done_cnt = 0;
    int          stab_err = 0;
    int          wait_err = 0;
    bit          busy_seen = 0;
    bit          payload_phase = 0;
    bit          prev_pend = 0;
    logic [15:0] prev_a;
    logic [7:0]  prev_d;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen = 1;
        if (prev_pend && reset_n && (!mem_we || mem_addr !== prev_a || mem_din !== prev_d)) stab_err++;
        if (payload_phase && mem_we && !ioctl_wait) wait_err++;
        if (mem_we && mem_ready) got_q.push_back({mem_addr, mem_din});
        prev_pend = reset_n && mem_we && !mem_ready;
        prev_a = mem_addr;
        prev_d = mem_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wait_low();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ioctl_wait) begin ok = 1; break; end
            tick();
        end
        if (!ok) check("ioctl_wait_timeout", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin ok = 1; break; end
            tick();
        end
        if (!ok) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int a);
        wait_wait_low();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = b;
        tick();
        ioctl_wr = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Full load: computes the expected write stream from the file contents,
    // drives the download, then compares writes and final status
    task automatic run_load(input logic [7:0] f[$], input int bad_idx, input int mode,
                            output logic [31:0] g_end, output logic [31:0] g_err,
                            output logic [31:0] g_nw);
        int  e_end;
        bit  e_err;
        int  load;
        int  nw;
        int  n;
        logic [15:0] ev;
        n = f.size();
        exp_q.delete();
        e_end = 0;
        nw = 0;
        e_err = (bad_idx >= 0 && bad_idx < n);
        if (n < 2) begin
            e_err = 1;
        end else begin
            load = int'(f[0]) + 256 * int'(f[1]);
            for (int i = 2; i < n; i++) begin
                int a;
                a = load + i - 2;
                if (a < 65536) begin
                    exp_q.push_back({a[15:0], f[i]});
                    nw++;
                end else begin
                    e_err = 1;
                end
            end
            e_end = (load + n - 2 > 65536) ? 65536 : load + n - 2;
            ev = e_end[15:0];
            if (!e_err && nw > 0)
                for (int k = 0; k < 6; k++)
                    exp_q.push_back({16'(16'h002A + k), (k % 2 == 0) ? ev[7:0] : ev[15:8]});
        end

        got_q.delete();
        done_cnt = 0;
        stab_err = 0;
        wait_err = 0;
        rdy_mode = mode;
        ioctl_index = 8'h41;
        ioctl_download = 1'b1;
        tick();
        tick();
        payload_phase = 1;
        for (int i = 0; i < n; i++) send_byte(f[i], (i == bad_idx) ? i + 7 : i);
        wait_wait_low();
        payload_phase = 0;
        ioctl_download = 1'b0;
        wait_idle();
        tick();

        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("write_addr_data", 32'(got_q[i]), 32'(exp_q[i]));
        if (n >= 2) begin
            check("end_addr", 32'(end_addr), 32'(e_end));
            check("load_addr", 32'(load_addr), 32'(load[15:0]));
        end
        check("error", 32'(error), 32'(e_err));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("hold_stable", 32'(stab_err), 32'd0);
        check("wait_during_write", 32'(wait_err), 32'd0);
        g_end = 32'(end_addr);
        g_err = 32'(error);
        g_nw  = 32'(got_q.size());
    endtask

    typedef struct {
        int          len;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          bad;
        int          mode;
        logic [31:0] exp_end;
        logic [31:0] exp_err;
        logic [31:0] exp_nw;
        bit          chk_end;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  f[$];
        logic [31:0] g_end, g_err, g_nw;

        tbl[0] = '{6, 8'h01, 8'h04, -1, 0, 32'h0405,  32'd1 - 32'd1, 32'd10, 1'b1};
        tbl[1] = '{6, 8'h01, 8'h04, -1, 1, 32'h0405,  32'd0, 32'd10, 1'b1};
        tbl[2] = '{5, 8'hFE, 8'hFF, -1, 0, 32'h10000, 32'd1, 32'd2,  1'b1};
        tbl[3] = '{1, 8'h01, 8'h00, -1, 0, 32'h0,     32'd1, 32'd0,  1'b0};
        tbl[4] = '{2, 8'h00, 8'h10, -1, 2, 32'h1000,  32'd0, 32'd0,  1'b1};
        tbl[5] = '{6, 8'h00, 8'h20,  3, 2, 32'h2004,  32'd1, 32'd4,  1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst_end_addr", 32'(end_addr), 32'd0);
        check("rst_load_addr", 32'(load_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        // Directed table
        for (int t = 0; t < 6; t++) begin
            f.delete();
            f.push_back(tbl[t].lo);
            if (tbl[t].len > 1) f.push_back(tbl[t].hi);
            for (int i = 0; i < tbl[t].len - 2; i++) f.push_back(8'hAA + 8'(17 * i));
            run_load(f, tbl[t].bad, tbl[t].mode, g_end, g_err, g_nw);
            if (tbl[t].chk_end) check("tbl_end_addr", g_end, tbl[t].exp_end);
            check("tbl_error", g_err, tbl[t].exp_err);
            check("tbl_nwrites", g_nw, tbl[t].exp_nw);
        end

        // Wrong index: loader must stay idle
        got_q.delete();
        done_cnt = 0;
        busy_seen = 0;
        rdy_mode = 0;
        ioctl_index = 8'h01;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 3);
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        ioctl_download = 1'b0;
        repeat (5) tick();
        check("wrong_idx_busy", 32'(busy_seen), 32'd0);
        check("wrong_idx_writes", 32'(got_q.size()), 32'd0);
        check("wrong_idx_done", 32'(done_cnt), 32'd0);

        // Byte strobe while ioctl_wait is high: ignored, flags error
        got_q.delete();
        done_cnt = 0;
        rdy_mode = 3;
        ioctl_index = 8'h41;
        ioctl_download = 1'b1;
        tick();
        tick();
        send_byte(8'h00, 0);
        send_byte(8'h20, 1);
        send_byte(8'h55, 2);
        tick();
        check("viol_wait_high", 32'(ioctl_wait), 32'd1);
        ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h66;
        tick();
        ioctl_wr = 1'b0;
        rdy_mode = 0;
        wait_wait_low();
        ioctl_download = 1'b0;
        wait_idle();
        tick();
        check("viol_writes", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("viol_write0", 32'(got_q[0]), 32'h200055);
        check("viol_error", 32'(error), 32'd1);
        check("viol_end_addr", 32'(end_addr), 32'h2001);
        check("viol_done", 32'(done_cnt), 32'd1);

        // Reset while a payload write is pending
        got_q.delete();
        rdy_mode = 3;
        ioctl_index = 8'h41;
        ioctl_download = 1'b1;
        tick();
        tick();
        send_byte(8'h00, 0);
        send_byte(8'h30, 1);
        send_byte(8'h77, 2);
        tick();
        check("pre_rst_mem_we", 32'(mem_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        ioctl_download = 1'b0;
        rdy_mode = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_writes", 32'(got_q.size()), 32'd0);
        f.delete();
        f.push_back(8'h00); f.push_back(8'h30); f.push_back(8'h11); f.push_back(8'h22);
        run_load(f, -1, 0, g_end, g_err, g_nw);
        check("post_rst_end", g_end, 32'h3002);

        // Randomized loads against the file-level model
        for (int r = 0; r < 10; r++) begin
            int len;
            f.delete();
            len = $urandom_range(2, 10);
            f.push_back(8'($urandom_range(0, 255)));
            f.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            if (f[1] == 8'hFF) f[0] = 8'($urandom_range(248, 255));
            for (int i = 2; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
            run_load(f, -1, $urandom_range(0, 2), g_end, g_err, g_nw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
